// File: rtl/sift_pkg.sv
// sift_pkg
// Shared constants and types for the SIFT keypoint path.
//   KP_ROW_W / KP_COL_W : RowCol field widths (row in the upper bits)
//   KP_ADDR_W / KP_DEPTH: keypoint SRAM address width and number of entries
//   kp_arb_state_t      : state encoding of the keypoint write arbiter
package sift_pkg;

    localparam int KP_ROW_W  = 9;
    localparam int KP_COL_W  = 10;
    localparam int KP_ADDR_W = 11;
    localparam int KP_DEPTH  = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } kp_arb_state_t;

    // Keypoints are accepted while a frame is running and while it drains.
    function automatic logic kp_state_accepts(input kp_arb_state_t s);
        return (s == RUN) || (s == FLUSH);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter: combinational one-hot grant plus a registered
// priority pointer.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous pointer clear (start of a new frame)
//   enable   : grants are only issued while enable is high
//   req[1:0] : request lines
//   grant    : one-hot (or zero) grant, combinational
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic rr_ptr;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    // The pointer moves to the other side only after a contended grant, so a
    // single active requester does not disturb the fairness order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (clear) begin
            rr_ptr <= 1'b0;
        end else if (enable && (req == 2'b11)) begin
            rr_ptr <= ~rr_ptr;
        end
    end

endmodule

// File: rtl/keypoint_write_arbiter.sv
// keypoint_write_arbiter
// Merges keypoints from two detectors into the keypoint SRAM with a
// round-robin grant, one registered write per accepted keypoint, and a frame
// FSM (IDLE -> RUN -> FLUSH -> DONE -> IDLE).
// Optional build macro: KP_TAG_EN adds the granted requester index as
// kp_din[DATA_W] above the RowCol.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, frame_end         : frame begin pulse, last-row-done pulse
//   req{0,1}_valid/data      : offered keypoints
//   req{0,1}_ready           : combinational accept
//   kp_we, kp_addr, kp_din   : registered SRAM write port
//   kp_count                 : keypoints stored this frame
//   overflow                 : sticky, a keypoint was dropped because full
//   busy, done               : not-IDLE flag, end-of-frame pulse
module keypoint_write_arbiter
    import sift_pkg::*;
#(
    parameter int DATA_W = KP_ROW_W + KP_COL_W,
    parameter int ADDR_W = KP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              frame_end,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              kp_we,
    output logic [ADDR_W-1:0] kp_addr,
`ifdef KP_TAG_EN
    output logic [DATA_W:0]   kp_din,
`else
    output logic [DATA_W-1:0] kp_din,
`endif
    output logic [ADDR_W:0]   kp_count,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    kp_arb_state_t     state;
    logic              accepting;
    logic              frame_start;
    logic [1:0]        grant;
    logic              handshake;
    logic              full;
    logic              store;
    logic [DATA_W-1:0] grant_data;

    assign accepting   = kp_state_accepts(state);
    assign frame_start = (state == IDLE) && start;

    rr_arbiter2 u_rr_arbiter2 (
        .clk    (clk),
        .rst    (rst),
        .clear  (frame_start),
        .enable (accepting),
        .req    ({req1_valid, req0_valid}),
        .grant  (grant)
    );

    // Grants only exist for asserted valids, so any grant is a handshake.
    // When the SRAM is full the grant still goes out and the keypoint is
    // silently dropped, keeping the detectors from ever stalling.
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign handshake  = |grant;
    assign full       = (kp_count == FULL_COUNT);
    assign store      = handshake && !full;
    assign grant_data = grant[1] ? req1_data : req0_data;

    // Frame sequencing; busy and done are registered alongside the state so
    // they always track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (frame_end) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!req0_valid && !req1_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Write port and per-frame bookkeeping. The address of a store is the
    // count before it increments, so writes land at 0,1,2,... each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kp_we    <= 1'b0;
            kp_addr  <= '0;
            kp_din   <= '0;
            kp_count <= '0;
            overflow <= 1'b0;
        end else begin
            kp_we <= store;
            if (store) begin
                kp_addr  <= kp_count[ADDR_W-1:0];
`ifdef KP_TAG_EN
                kp_din   <= {grant[1], grant_data};
`else
                kp_din   <= grant_data;
`endif
                kp_count <= kp_count + 1'b1;
            end
            if (handshake && full) begin
                overflow <= 1'b1;
            end
            if (frame_start) begin
                kp_count <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypoint_write_arbiter.sv
// tb_keypoint_write_arbiter
// Self-checking bench for keypoint_write_arbiter: a transaction-level model
// (stored keypoints kept in a queue) is compared against the DUT on every
// falling edge, plus directed scenarios with literal expectations.
// Honours KP_TAG_EN the same way as the design.
module tb_keypoint_write_arbiter;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
`ifdef KP_TAG_EN
    localparam int DIN_W = DATA_W + 1;
`else
    localparam int DIN_W = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              frame_end;
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req0_ready;
    logic              req1_ready;
    logic              kp_we;
    logic [ADDR_W-1:0] kp_addr;
    logic [DIN_W-1:0]  kp_din;
    logic [ADDR_W:0]   kp_count;
    logic              overflow;
    logic              busy;
    logic              done;

    int checkCount = 0;
    int errorCount = 0;

    keypoint_write_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_end  (frame_end),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .kp_we      (kp_we),
        .kp_addr    (kp_addr),
        .kp_din     (kp_din),
        .kp_count   (kp_count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle with the given inputs; returns just after the rising edge.
    task automatic applyStimulus(input logic s, input logic fe,
                                 input logic v0, input logic [DATA_W-1:0] d0,
                                 input logic v1, input logic [DATA_W-1:0] d1);
        start      = s;
        frame_end  = fe;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic logic [DIN_W-1:0] expWord(input int src, input logic [DATA_W-1:0] d);
        logic [DIN_W-1:0] w;
        w = DIN_W'(d);
`ifdef KP_TAG_EN
        w[DATA_W] = (src == 1);
`endif
        return w;
    endfunction

    // ---------------- reference model ----------------
    // mPhase: 0 idle, 1 running, 2 draining, 3 finished
    int               mPhase;
    int               mPtr;
    bit               mOverflow;
    bit               mWe;
    int               mAddr;
    logic [DIN_W-1:0] mDin;
    logic [DIN_W-1:0] mStored[$];

    function automatic int modelGrant();
        if (mPhase != 1 && mPhase != 2) return -1;
        if (req0_valid && req1_valid) return mPtr;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            mPhase    = 0;
            mPtr      = 0;
            mOverflow = 0;
            mWe       = 0;
            mAddr     = 0;
            mDin      = '0;
            mStored.delete();
        end else begin
            g   = modelGrant();
            mWe = 0;
            if (g >= 0) begin
                if (mStored.size() < DEPTH) begin
                    mStored.push_back(expWord(g, (g == 1) ? req1_data : req0_data));
                    mWe   = 1;
                    mAddr = mStored.size() - 1;
                    mDin  = mStored[mStored.size() - 1];
                end else begin
                    mOverflow = 1;
                end
                if (req0_valid && req1_valid) mPtr = 1 - mPtr;
            end
            case (mPhase)
                0: if (start) begin
                       mPhase = 1;
                       mStored.delete();
                       mOverflow = 0;
                       mPtr = 0;
                   end
                1: if (frame_end) mPhase = 2;
                2: if (!req0_valid && !req1_valid) mPhase = 3;
                default: mPhase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int g;
        g = modelGrant();
        checkOutput("req0_ready", 32'(req0_ready), 32'(g == 0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(g == 1));
        checkOutput("kp_we", 32'(kp_we), 32'(mWe));
        checkOutput("kp_addr", 32'(kp_addr), 32'(mAddr));
        checkOutput("kp_din", 32'(kp_din), 32'(mDin));
        checkOutput("kp_count", 32'(kp_count), 32'(mStored.size()));
        checkOutput("overflow", 32'(overflow), 32'(mOverflow));
        checkOutput("busy", 32'(busy), 32'(mPhase != 0));
        checkOutput("done", 32'(done), 32'(mPhase == 3));
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int drops;
        rst        = 1'b1;
        start      = 1'b0;
        frame_end  = 1'b0;
        req0_valid = 1'b0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_count", 32'(kp_count), 0);
        rst = 1'b0;

        // Valid without a start must not be accepted.
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00401, 1'b0, '0);
        checkOutput("no_start_we", 32'(kp_we), 0);

        // Single requester.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        checkOutput("start_busy", 32'(busy), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00401, 1'b0, '0);
        checkOutput("single_addr0", 32'(kp_addr), 0);
        checkOutput("single_din0", 32'(kp_din), 32'(expWord(0, 19'h00401)));
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00402, 1'b0, '0);
        checkOutput("single_addr1", 32'(kp_addr), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00403, 1'b0, '0);
        checkOutput("single_addr2", 32'(kp_addr), 2);
        checkOutput("single_we", 32'(kp_we), 1);
        idleCycle();
        checkOutput("single_we_off", 32'(kp_we), 0);
        checkOutput("single_count", 32'(kp_count), 3);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idleCycle();
        checkOutput("single_done", 32'(done), 1);
        idleCycle();
        checkOutput("single_done_off", 32'(done), 0);
        checkOutput("single_idle_count", 32'(kp_count), 3);

        // Contention: grants alternate 0,1,0,1.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00111, 1'b1, 19'h00222);
        checkOutput("cont_din0", 32'(kp_din), 32'(expWord(0, 19'h00111)));
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00111, 1'b1, 19'h00222);
        checkOutput("cont_din1", 32'(kp_din), 32'(expWord(1, 19'h00222)));
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00111, 1'b1, 19'h00222);
        checkOutput("cont_din2", 32'(kp_din), 32'(expWord(0, 19'h00111)));
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00111, 1'b1, 19'h00222);
        checkOutput("cont_din3", 32'(kp_din), 32'(expWord(1, 19'h00222)));
        checkOutput("cont_addr3", 32'(kp_addr), 3);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idleCycle();
        idleCycle();

        // Flush: start ignored while running, frame_end with a live handshake.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h00010, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 19'h00020);
        checkOutput("restart_ignored", 32'(kp_count), 2);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 19'h0A005);
        checkOutput("fe_store", 32'(kp_count), 3);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 19'h0A006);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 19'h0A007);
        checkOutput("flush_count", 32'(kp_count), 5);
        checkOutput("flush_din", 32'(kp_din), 32'(expWord(1, 19'h0A007)));
        idleCycle();
        checkOutput("flush_done", 32'(done), 1);
        checkOutput("flush_busy", 32'(busy), 1);
        idleCycle();
        checkOutput("flush_done_off", 32'(done), 0);
        checkOutput("flush_busy_off", 32'(busy), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        checkOutput("fe_idle_ignored", 32'(busy), 0);

        // Full SRAM: 2050 offers, last two dropped, ready never drops.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        drops = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            req0_valid = 1'b1;
            req0_data  = DATA_W'(i);
            #2;
            if (req0_ready !== 1'b1) drops++;
            @(posedge clk);
            #1;
            if (i == DEPTH - 1) begin
                checkOutput("full_last_addr", 32'(kp_addr), 2047);
                checkOutput("full_last_count", 32'(kp_count), 2048);
                checkOutput("full_no_ovf_yet", 32'(overflow), 0);
            end
        end
        checkOutput("full_ready_held", 32'(drops), 0);
        checkOutput("full_count", 32'(kp_count), 2048);
        checkOutput("full_overflow", 32'(overflow), 1);
        checkOutput("full_we_off", 32'(kp_we), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        idleCycle();
        idleCycle();
        checkOutput("ovf_held_idle", 32'(overflow), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        checkOutput("start_clears_ovf", 32'(overflow), 0);
        checkOutput("start_clears_count", 32'(kp_count), 0);

        // Reset mid-frame at kp_count = 100.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(i + 19'h00300), 1'b0, '0);
        end
        checkOutput("pre_reset_count", 32'(kp_count), 100);
        rst = 1'b1;
        #1;
        checkOutput("rst_count", 32'(kp_count), 0);
        checkOutput("rst_we", 32'(kp_we), 0);
        checkOutput("rst_addr", 32'(kp_addr), 0);
        checkOutput("rst_din", 32'(kp_din), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ready", 32'(req0_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h12345, 1'b0, '0);
        checkOutput("post_rst_nostart", 32'(kp_count), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 19'h12345, 1'b0, '0);
        checkOutput("restart_addr", 32'(kp_addr), 0);
        checkOutput("restart_din", 32'(kp_din), 32'(expWord(0, 19'h12345)));
        checkOutput("restart_count", 32'(kp_count), 1);
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/keypoint_write_arbiter.md
KEYPOINT_WRITE_ARBITER -- requirements
Module: keypoint_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 19, the keypoint RowCol width: row 9 bits [18:10], col 10 bits [9:0].
REQ-002 The block SHALL have parameter ADDR_W, default 11, the keypoint SRAM address width (2048 entries).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: pulse that begins a frame; honoured only in IDLE.
REQ-006 The block SHALL have port frame_end, input, 1 bit: pulse from the detect/filter sequencer marking the last image row done.
REQ-007 The block SHALL have ports req0_valid and req1_valid, each input, 1 bit: a keypoint is offered by detector 0 or detector 1.
REQ-008 The block SHALL have ports req0_data and req1_data, each input, DATA_W bits: the offered RowCol.
REQ-009 The block SHALL have ports req0_ready and req1_ready, each output, 1 bit: combinational accept for the offered keypoint.
REQ-010 The block SHALL have port kp_we, output, 1 bit: registered keypoint SRAM write enable.
REQ-011 The block SHALL have port kp_addr, output, ADDR_W bits: registered keypoint SRAM address.
REQ-012 The block SHALL have port kp_din, output, DATA_W+1 bits when KP_TAG_EN is defined and DATA_W bits otherwise: registered write data.
REQ-013 The block SHALL have port kp_count, output, ADDR_W+1 bits: number of keypoints stored this frame.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a keypoint was dropped because the SRAM was full.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FLUSH, DONE.
REQ-018 Transitions SHALL be: IDLE->RUN on start; RUN->FLUSH on frame_end; FLUSH->DONE on the first cycle with both valids low; DONE->IDLE unconditionally.
REQ-019 A start pulse outside IDLE SHALL be ignored.
REQ-020 In IDLE and DONE, both readys SHALL be 0.
REQ-021 The block SHALL accept keypoints only in RUN and FLUSH.
REQ-022 In RUN and FLUSH, at most one ready SHALL be high per cycle.
REQ-023 If only one valid is high, that requester SHALL be granted.
REQ-024 If both valids are high, the requester selected by rr_ptr SHALL be granted.
REQ-025 rr_ptr SHALL flip to the other requester after every grant made while both valids are high; rr_ptr resets to 0.
REQ-026 A handshake (valid && ready) when kp_count < 2048 SHALL produce, on the next cycle, kp_we=1, kp_addr=kp_count[ADDR_W-1:0] and kp_din=data.
REQ-027 On that same edge kp_count SHALL increment by 1.
REQ-028 Write latency SHALL be exactly 1 cycle, with back-to-back writes every cycle; kp_we SHALL be 0 in any cycle following no store.
REQ-029 When kp_count == 2048 (full), the granted ready SHALL still assert so upstream never stalls.
REQ-030 When full, the accepted keypoint SHALL be dropped: no kp_we, kp_count unchanged, and overflow set.
REQ-031 frame_end arriving in the same cycle as a handshake SHALL still store that keypoint.
REQ-032 frame_end outside RUN SHALL be ignored.
REQ-033 The start pulse in IDLE SHALL clear kp_count, overflow and rr_ptr.
REQ-034 kp_count and overflow SHALL hold their values in DONE and IDLE until the next start.
REQ-035 done SHALL be 1 exactly in the DONE state.

Reset
REQ-036 Asserting rst, at any time including mid-frame, SHALL immediately force IDLE, kp_we=0, kp_addr=0, kp_din=0, kp_count=0, overflow=0, rr_ptr=0, done=0 and busy=0.
REQ-037 The first frame after reset deassertion SHALL require a fresh start.

Configuration
REQ-038 With KP_TAG_EN defined, kp_din[DATA_W] SHALL carry the granted requester index (0 or 1) above the RowCol.
REQ-039 Without KP_TAG_EN, kp_din SHALL be the RowCol only; arbitration behaviour is identical in both builds.

Structure
REQ-040 A shared package sift_pkg SHALL hold KP_ROW_W=9, KP_COL_W=10, KP_ADDR_W=11 and KP_DEPTH=2048.
REQ-041 sift_pkg SHALL hold the FSM state encoding typedef kp_arb_state_t.
REQ-042 The grant logic SHALL be a sub-module rr_arbiter2 (2-way round-robin, combinational grant plus registered pointer).

Verification
REQ-043 Single requester: start, then req0_valid for 3 cycles with data 0x00401, 0x00402, 0x00403 -> kp_we on cycles 1-3 at kp_addr 0,1,2 and kp_count=3.
REQ-044 Contention: both valids held for 4 cycles -> grants alternate 0,1,0,1 and kp_din sources alternate.
REQ-045 Contention with KP_TAG_EN: same stimulus as REQ-044 -> kp_din[19] sequence 0,1,0,1.
REQ-046 Full: 2050 keypoints offered -> kp_count=2048, the last write at kp_addr 2047, overflow=1, and ready never deasserts.
REQ-047 Flush: frame_end while req1_valid is held 2 more cycles -> both keypoints stored, then done pulses once and busy falls on the next cycle.
REQ-048 Reset mid-frame: rst asserted at kp_count=100 -> all outputs zero in the same cycle; a start after release restarts at kp_addr 0.
